// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, fault codes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_BUS      = 2'd2,
        FAULT_ILLEGAL  = 2'd3
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // An access is aligned when the address is a multiple of its size in bytes.
    function automatic logic is_misaligned(input size_e size, input logic [2:0] addr_lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data placement and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN   = 64,
    localparam int STRB_W = XLEN / 8,
    localparam int LANE_W = $clog2(STRB_W)
) (
    input  size_e              i_size,
    input  logic [LANE_W-1:0]  i_addr_lo,
    input  logic               i_unsigned,
    input  logic [XLEN-1:0]    i_wdata,
    input  logic [XLEN-1:0]    i_rdata,
    output logic [STRB_W-1:0]  o_wstrb,
    output logic [XLEN-1:0]    o_wdata,
    output logic [XLEN-1:0]    o_rdata
);

    logic [STRB_W-1:0] w_strb_base;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_low_mask;
    logic              w_sign;
    logic [LANE_W+2:0] w_bit_shift;

    assign w_bit_shift = {i_addr_lo, 3'b000};
    assign w_rshift    = i_rdata >> w_bit_shift;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_strb_base = '1;
        w_low_mask  = '1;
        w_sign      = w_rshift[XLEN-1];
        case (i_size)
            SIZE_B: begin
                w_strb_base = STRB_W'(1);
                w_low_mask  = XLEN'(64'h0000_0000_0000_00FF);
                w_sign      = w_rshift[7];
            end
            SIZE_H: begin
                w_strb_base = STRB_W'(3);
                w_low_mask  = XLEN'(64'h0000_0000_0000_FFFF);
                w_sign      = w_rshift[15];
            end
            SIZE_W: begin
                w_strb_base = STRB_W'(15);
                w_low_mask  = XLEN'(64'h0000_0000_FFFF_FFFF);
                w_sign      = w_rshift[31];
            end
            default: ;
        endcase
    end

    assign o_wstrb = w_strb_base << i_addr_lo;
    assign o_wdata = i_wdata << w_bit_shift;
    assign o_rdata = (w_rshift & w_low_mask) | ((w_sign && !i_unsigned) ? ~w_low_mask : '0);

endmodule

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store unit: accepts one op, issues one bus access, returns one response.
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_pc,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_wen,
    input  logic                req_ren,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_resp_rdata,
    input  logic                mem_resp_err,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]   rsp_pc,
    output logic [1:0]          rsp_fault
);

    localparam int STRB_W = XLEN / 8;
    localparam int LANE_W = $clog2(STRB_W);

    state_e              r_state;
    state_e              w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    size_e               r_size;
    logic                r_unsigned;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_rdata;
    fault_e              r_fault;

    size_e               w_req_size;
    fault_e              w_fault_in;
    logic                w_accept;
    logic                w_req_ready;
    logic                w_mem_req_valid;
    logic                w_rsp_valid;
    logic [STRB_W-1:0]   w_wstrb;
    logic [XLEN-1:0]     w_wdata_lanes;
    logic [XLEN-1:0]     w_load_data;

    assign w_req_size = size_e'(req_size);
    assign w_accept   = (r_state == ST_IDLE) && req_valid && (req_wen || req_ren);

    // Illegal size outranks misalignment; either one skips the bus entirely.
    always_comb begin
        w_fault_in = FAULT_NONE;
        if (XLEN == 32 && w_req_size == SIZE_D) begin
            w_fault_in = FAULT_ILLEGAL;
        end else if (is_misaligned(w_req_size, req_addr[2:0])) begin
            w_fault_in = FAULT_MISALIGN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_req_ready     = 1'b0;
        w_mem_req_valid = 1'b0;
        w_rsp_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = (w_fault_in == FAULT_NONE) ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                w_mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_size     <= SIZE_B;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_fault    <= FAULT_NONE;
        end else if (w_accept) begin
            r_pc       <= req_pc;
            r_addr     <= req_addr;
            r_wen      <= req_wen;
            r_size     <= w_req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_fault    <= w_fault_in;
        end else if (r_state == ST_WAIT && mem_resp_valid) begin
            r_fault <= mem_resp_err ? FAULT_BUS : FAULT_NONE;
            r_rdata <= (mem_resp_err || r_wen) ? '0 : w_load_data;
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[LANE_W-1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_resp_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata_lanes),
        .o_rdata    (w_load_data)
    );

    // Outputs read as zero outside the state that qualifies them, including during reset.
    assign req_ready     = w_req_ready & rst_n;
    assign mem_req_valid = w_mem_req_valid;
    assign mem_req_addr  = w_mem_req_valid ? {r_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
    assign mem_req_we    = w_mem_req_valid & r_wen;
    assign mem_req_wdata = w_mem_req_valid ? w_wdata_lanes : '0;
    assign mem_req_wstrb = w_mem_req_valid ? w_wstrb : '0;
    assign rsp_valid     = w_rsp_valid;
    assign rsp_rdata     = w_rsp_valid ? r_rdata : '0;
    assign rsp_pc        = w_rsp_valid ? r_pc : '0;
    assign rsp_fault     = w_rsp_valid ? r_fault : FAULT_NONE;

endmodule
